cache2w_miss_ctrl: RTL and testbench

Sequencing controller for the 2-set × 2-way cache array (5-bit address = 4-bit tag + 1-bit index, 4-bit data). It accepts one CPU read/write at a time and evaluates the array's lookup outputs for hit or miss. It selects a victim by valid/LRU, writes back dirty victims to memory, fills from memory over a req/ack handshake, and issues all array write and LRU-touch strobes. It sits between the CPU port, the cache array and main memory, and keeps saturating hit/miss statistics.

---
 rtl/cache2w_miss_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_cache2w_miss_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache2w_miss_ctrl.sv
// cache2w_miss_ctrl: sequencing controller for a 2-set x 2-way cache array.
// Handles one CPU access at a time: hit/miss lookup, victim choice by
// valid/LRU, dirty write-back, fill over a req/ack handshake, array update
// and LRU touch, plus saturating hit/miss statistics.
module cache2w_miss_ctrl (
    input  logic       clock,
    input  logic       resetn,
    input  logic       cpu_req,
    input  logic       cpu_write,
    input  logic [4:0] cpu_addr,
    input  logic [3:0] cpu_wdata,
    output logic       cpu_ready,
    output logic       cpu_done,
    output logic [3:0] cpu_rdata,
    output logic       arr_index,
    input  logic [1:0] way_valid,
    input  logic [1:0] way_dirty,
    input  logic [3:0] way_tag0,
    input  logic [3:0] way_tag1,
    input  logic [3:0] way_data0,
    input  logic [3:0] way_data1,
    input  logic       lru_way,
    output logic       arr_we,
    output logic       arr_way,
    output logic [3:0] arr_wtag,
    output logic [3:0] arr_wdata,
    output logic       arr_wdirty,
    output logic       arr_touch,
    output logic       arr_touch_way,
    output logic       mem_req,
    output logic       mem_we,
    output logic [4:0] mem_addr,
    output logic [3:0] mem_wdata,
    input  logic [3:0] mem_rdata,
    input  logic       mem_ack,
    output logic [7:0] hit_count,
    output logic [7:0] miss_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        WRITEBACK,
        FILL,
        UPDATE
    } state_t;

    state_t     state;
    state_t     next_state;

    logic [4:0] addr_q;
    logic       write_q;
    logic [3:0] wdata_q;
    logic       victim_way_q;
    logic [3:0] victim_tag_q;
    logic [3:0] victim_data_q;
    logic [3:0] fill_data_q;

    logic [3:0] req_tag;
    logic       hit0;
    logic       hit1;
    logic       hit;
    logic       hit_way;
    logic [3:0] hit_data;
    logic       victim_way;
    logic [3:0] victim_tag;
    logic [3:0] victim_data;
    logic       victim_needs_wb;

    assign req_tag   = addr_q[4:1];
    assign arr_index = addr_q[0];

    // Hit detection and victim choice from the array's view of the addressed set
    always_comb begin
        hit0     = way_valid[0] & (way_tag0 == req_tag);
        hit1     = way_valid[1] & (way_tag1 == req_tag);
        hit      = hit0 | hit1;
        hit_way  = hit0 ? 1'b0 : 1'b1;
        hit_data = hit0 ? way_data0 : way_data1;

        if (!way_valid[0]) begin
            victim_way = 1'b0;
        end else if (!way_valid[1]) begin
            victim_way = 1'b1;
        end else begin
            victim_way = lru_way;
        end
        victim_tag      = victim_way ? way_tag1 : way_tag0;
        victim_data     = victim_way ? way_data1 : way_data0;
        victim_needs_wb = way_valid[victim_way] & way_dirty[victim_way];
    end

    // State register; reset abandons any access in flight
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus all array and memory strobes
    always_comb begin
        next_state    = state;
        cpu_ready     = 1'b0;
        arr_we        = 1'b0;
        arr_way       = 1'b0;
        arr_wtag      = req_tag;
        arr_wdata     = wdata_q;
        arr_wdirty    = 1'b0;
        arr_touch     = 1'b0;
        arr_touch_way = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = addr_q;
        mem_wdata     = victim_data_q;

        case (state)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) begin
                    next_state = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    arr_touch     = 1'b1;
                    arr_touch_way = hit_way;
                    if (write_q) begin
                        arr_we     = 1'b1;
                        arr_way    = hit_way;
                        arr_wdirty = 1'b1;
                    end
                    next_state = IDLE;
                end else if (victim_needs_wb) begin
                    next_state = WRITEBACK;
                end else begin
                    next_state = FILL;
                end
            end
            WRITEBACK: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = {victim_tag_q, addr_q[0]};
                if (mem_ack) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    next_state = UPDATE;
                end
            end
            UPDATE: begin
                arr_we        = 1'b1;
                arr_way       = victim_way_q;
                arr_wdata     = write_q ? wdata_q : fill_data_q;
                arr_wdirty    = write_q;
                arr_touch     = 1'b1;
                arr_touch_way = victim_way_q;
                next_state    = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request latches, victim capture, fill capture, CPU response and statistics
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q        <= 5'd0;
            write_q       <= 1'b0;
            wdata_q       <= 4'd0;
            victim_way_q  <= 1'b0;
            victim_tag_q  <= 4'd0;
            victim_data_q <= 4'd0;
            fill_data_q   <= 4'd0;
            cpu_done      <= 1'b0;
            cpu_rdata     <= 4'd0;
            hit_count     <= 8'd0;
            miss_count    <= 8'd0;
        end else begin
            cpu_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        write_q <= cpu_write;
                        wdata_q <= cpu_wdata;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        cpu_done <= 1'b1;
                        if (!write_q) begin
                            cpu_rdata <= hit_data;
                        end
                        if (hit_count != 8'hFF) begin
                            hit_count <= hit_count + 8'd1;
                        end
                    end else begin
                        victim_way_q  <= victim_way;
                        victim_tag_q  <= victim_tag;
                        victim_data_q <= victim_data;
                        if (miss_count != 8'hFF) begin
                            miss_count <= miss_count + 8'd1;
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        fill_data_q <= mem_rdata;
                    end
                end
                UPDATE: begin
                    cpu_done <= 1'b1;
                    if (!write_q) begin
                        cpu_rdata <= fill_data_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache2w_miss_ctrl.sv
// tb_cache2w_miss_ctrl: bench for cache2w_miss_ctrl with a behavioural cache
// array, a memory responder and a scoreboard of expected CPU completions.
module tb_cache2w_miss_ctrl;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       cpu_req = 1'b0;
    logic       cpu_write = 1'b0;
    logic [4:0] cpu_addr = 5'd0;
    logic [3:0] cpu_wdata = 4'd0;
    logic       cpu_ready;
    logic       cpu_done;
    logic [3:0] cpu_rdata;
    logic       arr_index;
    logic [1:0] way_valid;
    logic [1:0] way_dirty;
    logic [3:0] way_tag0;
    logic [3:0] way_tag1;
    logic [3:0] way_data0;
    logic [3:0] way_data1;
    logic       lru_way;
    logic       arr_we;
    logic       arr_way;
    logic [3:0] arr_wtag;
    logic [3:0] arr_wdata;
    logic       arr_wdirty;
    logic       arr_touch;
    logic       arr_touch_way;
    logic       mem_req;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [3:0] mem_wdata;
    logic [3:0] mem_rdata = 4'd0;
    logic       mem_ack = 1'b0;
    logic [7:0] hit_count;
    logic [7:0] miss_count;

    int check_cnt = 0;
    int pass_cnt = 0;

    typedef struct packed {
        logic       is_read;
        logic [3:0] rdata;
        logic [7:0] lat;
    } exp_t;

    exp_t exp_q[$];

    cache2w_miss_ctrl dut (
        .clock(clock), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .arr_index(arr_index), .way_valid(way_valid), .way_dirty(way_dirty),
        .way_tag0(way_tag0), .way_tag1(way_tag1), .way_data0(way_data0), .way_data1(way_data1),
        .lru_way(lru_way), .arr_we(arr_we), .arr_way(arr_way), .arr_wtag(arr_wtag),
        .arr_wdata(arr_wdata), .arr_wdirty(arr_wdirty), .arr_touch(arr_touch),
        .arr_touch_way(arr_touch_way), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    // Cache array model: entry index is {set, way}; lru per set
    logic       m_valid [4];
    logic       m_dirty [4];
    logic [3:0] m_tag   [4];
    logic [3:0] m_data  [4];
    logic       m_lru   [2];
    logic       load_en = 1'b0;
    logic [3:0] ld_valid = 4'd0;
    logic [3:0] ld_dirty = 4'd0;
    logic [15:0] ld_tag = 16'd0;
    logic [15:0] ld_data = 16'd0;
    logic [1:0] ld_lru = 2'd0;
    int         we_cnt = 0;
    logic       last_touch_way = 1'b0;

    always_comb begin
        way_valid = {m_valid[{arr_index, 1'b1}], m_valid[{arr_index, 1'b0}]};
        way_dirty = {m_dirty[{arr_index, 1'b1}], m_dirty[{arr_index, 1'b0}]};
        way_tag0  = m_tag[{arr_index, 1'b0}];
        way_tag1  = m_tag[{arr_index, 1'b1}];
        way_data0 = m_data[{arr_index, 1'b0}];
        way_data1 = m_data[{arr_index, 1'b1}];
        lru_way   = m_lru[arr_index];
    end

    always @(posedge clock) begin
        if (load_en) begin
            for (int i = 0; i < 4; i++) begin
                m_valid[i] <= ld_valid[i];
                m_dirty[i] <= ld_dirty[i];
                m_tag[i]   <= ld_tag[i*4 +: 4];
                m_data[i]  <= ld_data[i*4 +: 4];
            end
            m_lru[0] <= ld_lru[0];
            m_lru[1] <= ld_lru[1];
        end else begin
            if (arr_we) begin
                m_valid[{arr_index, arr_way}] <= 1'b1;
                m_dirty[{arr_index, arr_way}] <= arr_wdirty;
                m_tag[{arr_index, arr_way}]   <= arr_wtag;
                m_data[{arr_index, arr_way}]  <= arr_wdata;
                we_cnt <= we_cnt + 1;
            end
            if (arr_touch) begin
                m_lru[arr_index] <= ~arr_touch_way;
                last_touch_way   <= arr_touch_way;
            end
        end
    end

    // Memory model: mem_req held for mem_wait cycles, then one ack cycle
    int         mem_wait = 0;
    int         wait_cnt = 0;
    int         wb_cnt = 0;
    int         fill_cnt = 0;
    int         req_cycles = 0;
    logic [4:0] last_wb_addr = 5'd0;
    logic [3:0] last_wb_data = 4'd0;
    logic [4:0] last_fill_addr = 5'd0;
    logic [3:0] fill_value = 4'd0;
    logic       spurious_ack = 1'b0;

    always @(negedge clock) begin
        mem_ack = 1'b0;
        if (spurious_ack) begin
            mem_ack = 1'b1;
        end else if (mem_req) begin
            req_cycles++;
            if (wait_cnt >= mem_wait) begin
                mem_ack  = 1'b1;
                wait_cnt = 0;
                if (mem_we) begin
                    wb_cnt++;
                    last_wb_addr = mem_addr;
                    last_wb_data = mem_wdata;
                end else begin
                    fill_cnt++;
                    last_fill_addr = mem_addr;
                    mem_rdata = fill_value;
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Loads the array model; called and returning at a falling edge
    task automatic preload(input logic [3:0] v, input logic [3:0] d, input logic [15:0] tags,
                           input logic [15:0] datas, input logic [1:0] lru);
        ld_valid = v;
        ld_dirty = d;
        ld_tag   = tags;
        ld_data  = datas;
        ld_lru   = lru;
        load_en  = 1'b1;
        @(negedge clock);
        load_en  = 1'b0;
    endtask

    task automatic preload_standard();
        preload(4'b1111, 4'b0000, 16'h3210, 16'h3210, 2'b00);
    endtask

    // Drives one request and waits (bounded) for cpu_done; lat counts falling edges after accept
    task automatic applyStimulus(input logic wr, input logic [4:0] addr, input logic [3:0] wd,
                                 output logic [7:0] lat, output logic [3:0] rd, output logic to);
        cpu_req   = 1'b1;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wd;
        @(posedge clock);
        @(negedge clock);
        cpu_req = 1'b0;
        lat = 8'd0;
        rd  = 4'd0;
        to  = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            if (cpu_done) begin
                lat = 8'(n);
                rd  = cpu_rdata;
                to  = 1'b0;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        check_cnt++; if (cpu_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %0b expected 1", cpu_ready); else pass_cnt++;
        check_cnt++; if (cpu_done !== 1'b0) $display("[TB] FAIL reset_done: got %0b expected 0", cpu_done); else pass_cnt++;
        check_cnt++; if (cpu_rdata !== 4'd0) $display("[TB] FAIL reset_rdata: got %0h expected 0", cpu_rdata); else pass_cnt++;
        check_cnt++; if (hit_count !== 8'd0 || miss_count !== 8'd0) $display("[TB] FAIL reset_counts: got %0d/%0d expected 0/0", hit_count, miss_count); else pass_cnt++;
        check_cnt++; if ({mem_req, mem_we, arr_we, arr_touch} !== 4'b0000) $display("[TB] FAIL reset_strobes: got %b expected 0000", {mem_req, mem_we, arr_we, arr_touch}); else pass_cnt++;
        check_cnt++; if (arr_index !== 1'b0) $display("[TB] FAIL reset_index: got %0b expected 0", arr_index); else pass_cnt++;
        resetn = 1'b1;
        @(negedge clock);
        check_cnt++; if (cpu_ready !== 1'b1) $display("[TB] FAIL post_reset_ready: got %0b expected 1", cpu_ready); else pass_cnt++;
    endtask

    task automatic test_read_hit();
        logic [7:0] lat; logic [3:0] rd; logic to; exp_t e;
        preload_standard();
        exp_q.push_back('{is_read: 1'b1, rdata: 4'd1, lat: 8'd2});
        applyStimulus(1'b0, 5'b00010, 4'd0, lat, rd, to);
        e = exp_q.pop_front();
        check_cnt++; if (to || lat !== e.lat) $display("[TB] FAIL read_hit_latency: got %0d expected %0d", lat, e.lat); else pass_cnt++;
        check_cnt++; if (rd !== e.rdata) $display("[TB] FAIL read_hit_rdata: got %0h expected %0h", rd, e.rdata); else pass_cnt++;
        check_cnt++; if (last_touch_way !== 1'b1) $display("[TB] FAIL read_hit_touch: got %0b expected 1", last_touch_way); else pass_cnt++;
        check_cnt++; if (hit_count !== 8'd1) $display("[TB] FAIL read_hit_count: got %0d expected 1", hit_count); else pass_cnt++;
    endtask

    task automatic test_write_hit();
        logic [7:0] lat; logic [3:0] rd; logic to; exp_t e; int req0;
        req0 = req_cycles;
        exp_q.push_back('{is_read: 1'b0, rdata: 4'd0, lat: 8'd2});
        applyStimulus(1'b1, 5'b00000, 4'd7, lat, rd, to);
        e = exp_q.pop_front();
        check_cnt++; if (to || lat !== e.lat) $display("[TB] FAIL write_hit_latency: got %0d expected %0d", lat, e.lat); else pass_cnt++;
        check_cnt++; if (m_data[0] !== 4'd7 || m_dirty[0] !== 1'b1 || m_tag[0] !== 4'd0) $display("[TB] FAIL write_hit_line: got d%0h y%0b t%0h expected d7 y1 t0", m_data[0], m_dirty[0], m_tag[0]); else pass_cnt++;
        check_cnt++; if (req_cycles !== req0) $display("[TB] FAIL write_hit_memreq: got %0d cycles expected %0d", req_cycles, req0); else pass_cnt++;
        check_cnt++; if (m_lru[0] !== 1'b1) $display("[TB] FAIL write_hit_lru: got %0b expected 1", m_lru[0]); else pass_cnt++;
        check_cnt++; if (hit_count !== 8'd2) $display("[TB] FAIL write_hit_count: got %0d expected 2", hit_count); else pass_cnt++;
    endtask

    task automatic test_clean_miss();
        logic [7:0] lat; logic [3:0] rd; logic to; exp_t e; int wb0; int req0;
        preload_standard();
        mem_wait   = 3;
        fill_value = 4'd9;
        wb0  = wb_cnt;
        req0 = req_cycles;
        exp_q.push_back('{is_read: 1'b1, rdata: 4'd9, lat: 8'd7});
        applyStimulus(1'b0, 5'b01010, 4'd0, lat, rd, to);
        e = exp_q.pop_front();
        check_cnt++; if (to || lat !== e.lat) $display("[TB] FAIL clean_miss_latency: got %0d expected %0d", lat, e.lat); else pass_cnt++;
        check_cnt++; if (rd !== e.rdata) $display("[TB] FAIL clean_miss_rdata: got %0h expected %0h", rd, e.rdata); else pass_cnt++;
        check_cnt++; if (last_fill_addr !== 5'b01010) $display("[TB] FAIL clean_miss_fill_addr: got %b expected 01010", last_fill_addr); else pass_cnt++;
        check_cnt++; if (wb_cnt !== wb0) $display("[TB] FAIL clean_miss_no_wb: got %0d expected %0d", wb_cnt, wb0); else pass_cnt++;
        check_cnt++; if (req_cycles - req0 !== 4) $display("[TB] FAIL clean_miss_req_cycles: got %0d expected 4", req_cycles - req0); else pass_cnt++;
        check_cnt++; if (m_tag[0] !== 4'h5 || m_data[0] !== 4'h9 || m_dirty[0] !== 1'b0) $display("[TB] FAIL clean_miss_line: got t%0h d%0h y%0b expected t5 d9 y0", m_tag[0], m_data[0], m_dirty[0]); else pass_cnt++;
        check_cnt++; if (m_lru[0] !== 1'b1) $display("[TB] FAIL clean_miss_lru: got %0b expected 1", m_lru[0]); else pass_cnt++;
        check_cnt++; if (miss_count !== 8'd1 || hit_count !== 8'd2) $display("[TB] FAIL clean_miss_counts: got %0d/%0d expected 2/1", hit_count, miss_count); else pass_cnt++;
    endtask

    task automatic test_dirty_miss();
        logic [7:0] lat; logic [3:0] rd; logic to; exp_t e; int wb0; int req0;
        preload(4'b1111, 4'b0001, 16'h3210, 16'h3217, 2'b00);
        mem_wait   = 1;
        fill_value = 4'hA;
        wb0  = wb_cnt;
        req0 = req_cycles;
        exp_q.push_back('{is_read: 1'b1, rdata: 4'hA, lat: 8'd7});
        applyStimulus(1'b0, 5'b01100, 4'd0, lat, rd, to);
        e = exp_q.pop_front();
        check_cnt++; if (to || lat !== e.lat) $display("[TB] FAIL dirty_miss_latency: got %0d expected %0d", lat, e.lat); else pass_cnt++;
        check_cnt++; if (wb_cnt - wb0 !== 1 || last_wb_addr !== 5'b00000 || last_wb_data !== 4'd7) $display("[TB] FAIL dirty_miss_wb: got n%0d a%b d%0h expected n1 a00000 d7", wb_cnt - wb0, last_wb_addr, last_wb_data); else pass_cnt++;
        check_cnt++; if (last_fill_addr !== 5'b01100) $display("[TB] FAIL dirty_miss_fill_addr: got %b expected 01100", last_fill_addr); else pass_cnt++;
        check_cnt++; if (req_cycles - req0 !== 4) $display("[TB] FAIL dirty_miss_req_cycles: got %0d expected 4", req_cycles - req0); else pass_cnt++;
        check_cnt++; if (rd !== e.rdata) $display("[TB] FAIL dirty_miss_rdata: got %0h expected %0h", rd, e.rdata); else pass_cnt++;
        check_cnt++; if (m_tag[0] !== 4'h6 || m_data[0] !== 4'hA || m_dirty[0] !== 1'b0) $display("[TB] FAIL dirty_miss_line: got t%0h d%0h y%0b expected t6 dA y0", m_tag[0], m_data[0], m_dirty[0]); else pass_cnt++;
        check_cnt++; if (miss_count !== 8'd2) $display("[TB] FAIL dirty_miss_count: got %0d expected 2", miss_count); else pass_cnt++;
    endtask

    task automatic test_write_miss_invalid();
        logic [7:0] lat; logic [3:0] rd; logic to; exp_t e; int wb0;
        preload(4'b0111, 4'b0000, 16'h3210, 16'h3210, 2'b00);
        mem_wait   = 0;
        fill_value = 4'hC;
        wb0 = wb_cnt;
        exp_q.push_back('{is_read: 1'b0, rdata: 4'd0, lat: 8'd4});
        applyStimulus(1'b1, 5'b01101, 4'd5, lat, rd, to);
        e = exp_q.pop_front();
        check_cnt++; if (to || lat !== e.lat) $display("[TB] FAIL write_miss_latency: got %0d expected %0d", lat, e.lat); else pass_cnt++;
        check_cnt++; if (m_valid[3] !== 1'b1 || m_tag[3] !== 4'h6 || m_data[3] !== 4'h5 || m_dirty[3] !== 1'b1) $display("[TB] FAIL write_miss_line: got v%0b t%0h d%0h y%0b expected v1 t6 d5 y1", m_valid[3], m_tag[3], m_data[3], m_dirty[3]); else pass_cnt++;
        check_cnt++; if (m_tag[2] !== 4'h2 || m_data[2] !== 4'h2) $display("[TB] FAIL write_miss_way0_kept: got t%0h d%0h expected t2 d2", m_tag[2], m_data[2]); else pass_cnt++;
        check_cnt++; if (wb_cnt !== wb0 || last_fill_addr !== 5'b01101) $display("[TB] FAIL write_miss_mem: got wb%0d fill%b expected wb%0d fill01101", wb_cnt, last_fill_addr, wb0); else pass_cnt++;
        check_cnt++; if (miss_count !== 8'd3) $display("[TB] FAIL write_miss_count: got %0d expected 3", miss_count); else pass_cnt++;
    endtask

    task automatic test_dual_match();
        logic [7:0] lat; logic [3:0] rd; logic to; exp_t e;
        preload(4'b1111, 4'b0000, 16'h3310, 16'h3610, 2'b11);
        exp_q.push_back('{is_read: 1'b1, rdata: 4'd6, lat: 8'd2});
        applyStimulus(1'b0, 5'b00111, 4'd0, lat, rd, to);
        e = exp_q.pop_front();
        check_cnt++; if (to || lat !== e.lat) $display("[TB] FAIL dual_match_latency: got %0d expected %0d", lat, e.lat); else pass_cnt++;
        check_cnt++; if (rd !== e.rdata) $display("[TB] FAIL dual_match_rdata: got %0h expected %0h", rd, e.rdata); else pass_cnt++;
        check_cnt++; if (last_touch_way !== 1'b0) $display("[TB] FAIL dual_match_touch: got %0b expected 0", last_touch_way); else pass_cnt++;
        check_cnt++; if (hit_count !== 8'd3) $display("[TB] FAIL dual_match_count: got %0d expected 3", hit_count); else pass_cnt++;
    endtask

    task automatic test_reset_mid_fill();
        int we0; logic seen;
        preload_standard();
        mem_wait = 50;
        we0  = we_cnt;
        seen = 1'b0;
        cpu_req   = 1'b1;
        cpu_write = 1'b0;
        cpu_addr  = 5'b01010;
        @(negedge clock);
        cpu_req = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check_cnt++; if (seen !== 1'b1) $display("[TB] FAIL mid_fill_reached: got %0b expected 1", seen); else pass_cnt++;
        repeat (2) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        check_cnt++; if (mem_req !== 1'b0) $display("[TB] FAIL mid_fill_mem_req: got %0b expected 0", mem_req); else pass_cnt++;
        check_cnt++; if (cpu_ready !== 1'b1) $display("[TB] FAIL mid_fill_idle: got %0b expected 1", cpu_ready); else pass_cnt++;
        check_cnt++; if (hit_count !== 8'd0 || miss_count !== 8'd0) $display("[TB] FAIL mid_fill_counts: got %0d/%0d expected 0/0", hit_count, miss_count); else pass_cnt++;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        check_cnt++; if (we_cnt !== we0) $display("[TB] FAIL mid_fill_no_write: got %0d expected %0d", we_cnt, we0); else pass_cnt++;
        check_cnt++; if (cpu_done !== 1'b0 || mem_req !== 1'b0) $display("[TB] FAIL mid_fill_quiet: got done%0b req%0b expected 0 0", cpu_done, mem_req); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] lat; logic [3:0] rd; logic to; exp_t e; int we0;
        preload_standard();
        mem_wait = 0;
        for (int i = 0; i < 300; i++) begin
            exp_q.push_back('{is_read: 1'b1, rdata: 4'd1, lat: 8'd2});
            applyStimulus(1'b0, 5'b00010, 4'd0, lat, rd, to);
            e = exp_q.pop_front();
            check_cnt++; if (to || lat !== e.lat || rd !== e.rdata) $display("[TB] FAIL b2b_hit_%0d: got lat%0d d%0h expected lat%0d d%0h", i, lat, rd, e.lat, e.rdata); else pass_cnt++;
        end
        check_cnt++; if (hit_count !== 8'd255) $display("[TB] FAIL hit_saturate: got %0d expected 255", hit_count); else pass_cnt++;
        check_cnt++; if (miss_count !== 8'd0) $display("[TB] FAIL hit_saturate_miss: got %0d expected 0", miss_count); else pass_cnt++;
        we0 = we_cnt;
        #1 spurious_ack = 1'b1;
        @(negedge clock);
        #1 spurious_ack = 1'b0;
        repeat (2) @(negedge clock);
        check_cnt++; if (cpu_ready !== 1'b1 || mem_req !== 1'b0 || cpu_done !== 1'b0) $display("[TB] FAIL spurious_ack_state: got rdy%0b req%0b done%0b expected 1 0 0", cpu_ready, mem_req, cpu_done); else pass_cnt++;
        check_cnt++; if (we_cnt !== we0 || hit_count !== 8'd255 || miss_count !== 8'd0) $display("[TB] FAIL spurious_ack_effects: got we%0d h%0d m%0d expected we%0d h255 m0", we_cnt, hit_count, miss_count, we0); else pass_cnt++;
    endtask

    // Runs every scenario in order, then reports
    initial begin
        test_reset();
        test_read_hit();
        test_write_hit();
        test_clean_miss();
        test_dirty_miss();
        test_write_miss_invalid();
        test_dual_match();
        test_reset_mid_fill();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
